// File: rtl/ps2_pkg.sv
// ============================================================
// Module : ps2_pkg
// Shared PS/2 types, command/response codes and parity helper.
// Rev    : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  // Parity bit that makes the total count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================
// Module : ps2_line_sync
// Synchronizes raw PS/2 clock/data and flags falling clock edges.
// Rev    : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic line_clk_in,
  input  logic line_data_in,
  output logic clk_sync_out,
  output logic data_sync_out,
  output logic clk_fe_out
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  // Reset to the released (high) level so no false edge appears after reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync[0]  <= line_clk_in;
      r_data_sync[0] <= line_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_clk_sync[i]  <= r_clk_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_sync_out  = r_clk_sync[SYNC_STAGES-1];
  assign data_sync_out = r_data_sync[SYNC_STAGES-1];
  assign clk_fe_out    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================
// Module : ps2_host_tx
// PS/2 host-to-device command transmitter with line-level ACK check.
// Rev    : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid_in,
  input  logic [7:0] cmd_in,
  output logic       cmd_ready_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       ack_ok_out,
  output logic       error_out
);

  localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT      = c_CNT_W'(TIMEOUT_CYCLES);

  logic w_clk_sync, w_data_sync, w_clk_fe;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .line_clk_in   (ps2_clk_in),
    .line_data_in  (ps2_data_in),
    .clk_sync_out  (w_clk_sync),
    .data_sync_out (w_data_sync),
    .clk_fe_out    (w_clk_fe)
  );

  tx_state_t          r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]         r_cmd, w_cmd_nxt;
  logic               r_parity, w_parity_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_ack_ok, w_ack_ok_nxt;
  logic               w_timed, w_timeout, w_done;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_cmd     <= '0;
      r_parity  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ack_ok  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cmd     <= w_cmd_nxt;
      r_parity  <= w_parity_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ack_ok  <= w_ack_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cmd_nxt     = r_cmd;
    w_parity_nxt  = r_parity;
    w_data_oe_nxt = r_data_oe;
    w_ack_ok_nxt  = r_ack_ok;
    w_done        = 1'b0;
    w_timeout     = 1'b0;
    w_timed       = (r_state == RTS) || (r_state == DATA) ||
                    (r_state == ACK) || (r_state == WAIT_IDLE);

    // One counter serves as the inhibit timer and as the inter-edge watchdog.
    if (w_timed) begin
      w_cnt_nxt = w_clk_fe ? '0 : r_cnt + 1'b1;
      w_timeout = !w_clk_fe && (r_cnt == c_TIMEOUT);
    end

    case (r_state)
      IDLE: begin
        if (cmd_valid_in) begin
          w_cmd_nxt     = cmd_in;
          w_parity_nxt  = odd_parity(cmd_in);
          w_bit_cnt_nxt = '0;
          w_cnt_nxt     = '0;
          w_ack_ok_nxt  = 1'b0;
          w_state_nxt   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == c_INHIBIT_LAST) begin
          w_data_oe_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = RTS;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RTS, DATA: begin
        if (w_clk_fe) begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_state_nxt   = DATA;
          if (r_bit_cnt < 4'd8) begin
            w_data_oe_nxt = ~r_cmd[r_bit_cnt[2:0]];
          end else if (r_bit_cnt == 4'd8) begin
            w_data_oe_nxt = ~r_parity;
          end else begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = ACK;
          end
        end
      end
      ACK: begin
        if (w_clk_fe) begin
          w_ack_ok_nxt  = ~w_data_sync;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_state_nxt   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_clk_sync && w_data_sync) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort wins over completion so done and error can never coincide.
    if (w_timeout) begin
      w_state_nxt   = IDLE;
      w_data_oe_nxt = 1'b0;
      w_done        = 1'b0;
    end
  end

  assign ps2_clk_oe    = (r_state == INHIBIT);
  assign ps2_data_oe   = r_data_oe;
  assign cmd_ready_out = (r_state == IDLE);
  assign busy_out      = (r_state != IDLE);
  assign done_out      = w_done;
  assign ack_ok_out    = w_done & r_ack_ok;
  assign error_out     = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================
// Module : tb_ps2_host_tx
// Directed bench for ps2_host_tx with an open-collector device model.
// Rev    : 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 200;
  localparam int HP  = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, cmd_ready, busy, done, ack_ok, err;
  logic       line_clk, line_data;

  // Wired-AND bus: either side pulling low wins.
  assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign line_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .ps2_clk_in    (line_clk),
    .ps2_data_in   (line_data),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .cmd_valid_in  (cmd_valid),
    .cmd_in        (cmd),
    .cmd_ready_out (cmd_ready),
    .busy_out      (busy),
    .done_out      (done),
    .ack_ok_out    (ack_ok),
    .error_out     (err)
  );

  int         n_vec = 0, n_bad = 0;
  int         n_done = 0, n_err = 0, n_acc = 0;
  logic [7:0] exp_q[$];
  bit         exp_ack = 1'b0, exp_err = 1'b0, exp_rts_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // Bits the device must see after the start bit: {stop, parity, data}.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, b};
  endfunction

  // Cycle-level checker: busy/ready model, inhibit length, RTS timeout, done/error legality.
  bit   m_busy = 1'b0;
  int   inh_run = 0, rts_cyc = 0;
  logic prev_clkoe = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy     = 1'b0;
      inh_run    = 0;
      rts_cyc    = 0;
      prev_clkoe = 1'b0;
    end else begin
      check("busy", 32'(busy), 32'(m_busy));
      check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      if (!m_busy) begin
        check("clk_oe_idle", 32'(ps2_clk_oe), 0);
        check("data_oe_idle", 32'(ps2_data_oe), 0);
      end
      if (done || err) check("done_err_excl", 32'(done & err), 0);
      if (ps2_clk_oe) inh_run++;
      if (prev_clkoe && !ps2_clk_oe) begin
        check("inhibit_len", 32'(inh_run), INH);
        check("rts_start_drive", 32'(ps2_data_oe), 1);
        inh_run = 0;
        rts_cyc = 0;
      end else begin
        rts_cyc++;
      end
      prev_clkoe = ps2_clk_oe;
      if (done) begin
        n_done++;
        check("done_allowed", 32'(exp_err), 0);
        check("ack_ok", 32'(ack_ok), 32'(exp_ack));
      end
      if (err) begin
        n_err++;
        check("error_allowed", 32'(exp_err), 1);
        if (exp_rts_to) check("rts_timeout_cycles", 32'(rts_cyc), TO);
      end
      if (!m_busy && cmd_valid) begin
        exp_q.push_back(cmd);
        n_acc++;
        m_busy = 1'b1;
      end else if (done || err) begin
        m_busy = 1'b0;
      end
    end
  end

  // Device: reads start bit at RTS, then clocks; samples on each rising edge.
  task automatic dev_frame(input bit do_ack, input int stop_after, output logic [9:0] got);
    int w;
    got = '0;
    w = 0;
    while (!ps2_clk_oe) begin
      @(negedge clk);
      if (++w > 1000) begin fail_now("wait_inhibit"); return; end
    end
    w = 0;
    while (ps2_clk_oe) begin
      @(negedge clk);
      if (++w > 1000) begin fail_now("wait_rts"); return; end
    end
    repeat (3) @(negedge clk);
    check("start_bit", 32'(line_data), 0);
    repeat (HP - 3) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (stop_after != 0 && i > stop_after) return;
      if (i == 11 && do_ack) begin
        dev_data_low = 1'b1;
        repeat (HP / 2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) begin
        got[i-1] = line_data;
        repeat (HP) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [9:0] got, input logic [9:0] lit);
    logic [7:0] b;
    if (exp_q.size() == 0) begin
      fail_now({name, "_no_accept"});
    end else begin
      b = exp_q.pop_front();
      check({name, "_model"}, 32'(got), 32'(frame_bits(b)));
      check({name, "_literal"}, 32'(got), 32'(lit));
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    cmd       = b;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int w = 0;
    while (n_done < target && w < limit) begin @(posedge clk); w++; end
    check("done_count", 32'(n_done), 32'(target));
  endtask

  task automatic wait_err(input int target, input int limit);
    int w = 0;
    while (n_err < target && w < limit) begin @(posedge clk); w++; end
    check("error_count", 32'(n_err), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [9:0] got;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack_ok", 32'(ack_ok), 0);
    check("rst_error", 32'(err), 0);
    rst_n = 1'b1;

    // 0xED with device ACK.
    exp_ack = 1'b1; exp_err = 1'b0; exp_rts_to = 1'b0;
    send(8'hED);
    dev_frame(1'b1, 0, got);
    check_frame("frame_ED", got, 10'h3ED);
    wait_done(1, 500);

    // 0x01, device leaves data high in the ACK slot.
    exp_ack = 1'b0;
    send(8'h01);
    dev_frame(1'b0, 0, got);
    check_frame("frame_01", got, 10'h201);
    wait_done(2, 500);
    #1;
    check("ready_after_done", 32'(cmd_ready), 1);

    // 0x00, device never clocks.
    exp_err = 1'b1; exp_rts_to = 1'b1;
    send(8'h00);
    wait_err(1, 600);
    #1;
    check("to_clk_oe", 32'(ps2_clk_oe), 0);
    check("to_data_oe", 32'(ps2_data_oe), 0);
    check("to_no_done", 32'(n_done), 2);
    void'(exp_q.pop_front());

    // Asynchronous reset after fe 5 of a 0x00 frame.
    exp_err = 1'b0; exp_rts_to = 1'b0;
    send(8'h00);
    dev_frame(1'b0, 5, got);
    @(posedge clk); #2;
    check("pre_rst_data_oe", 32'(ps2_data_oe), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_data_oe", 32'(ps2_data_oe), 0);
    check("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("async_rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready), 1);
    check("post_rst_busy", 32'(busy), 0);

    // Held valid: 0xFF, then 0xEE offered during the frame.
    exp_ack = 1'b1;
    @(posedge clk); #1;
    cmd = 8'hFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd = 8'hEE;
    dev_frame(1'b1, 0, got);
    check_frame("frame_FF", got, 10'h3FF);
    check("held_single_accept", 32'(n_acc), 5);
    wait_done(3, 500);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    dev_frame(1'b1, 0, got);
    check_frame("frame_EE", got, 10'h3EE);
    wait_done(4, 500);
    check("held_accept_count", 32'(n_acc), 6);

    // Device stops after fe 6, then a normal 0xED frame.
    exp_err = 1'b1;
    send(8'hED);
    dev_frame(1'b1, 6, got);
    wait_err(2, 600);
    void'(exp_q.pop_front());
    exp_err = 1'b0;
    send(8'hED);
    dev_frame(1'b1, 0, got);
    check_frame("frame_ED_retry", got, 10'h3ED);
    wait_done(5, 500);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
